aemb_dwb_ram: RTL and testbench
===============================

# aemb_dwb_ram

Wishbone data-bus responder for the AEMB core: a single-port word-organised RAM that answers the core's data-bus load/store requests. Each transfer completes with a one-cycle acknowledge after a configurable number of wait states. Stores write only the byte lanes selected by the core, and loads always return the full 32-bit word. Big-endian lane mapping matches the core's load/store sizer.

## Interface
- AW, 10, word-address width; memory depth is 2^AW 32-bit words.
- WAIT, 1, wait states inserted before acknowledge, range 0..15.

- gclk  in  1  system clock; all state changes on the rising edge.
- grst_n  in  1  reset, asynchronous assert, active-low.
- dwb_stb_i  in  1  request strobe from the core, held until acknowledged.
- dwb_wre_i  in  1  1 = store, 0 = load; valid while dwb_stb_i=1.
- dwb_adr_i  in  AW  word address, byte address bits [AW+1:2].
- dwb_sel_i  in  4  byte-lane select; bit3 = dat[31:24] … bit0 = dat[7:0].
- dwb_dat_i  in  32  store data, already lane-replicated by the core.
- dwb_dat_o  out  32  load data, valid while dwb_ack_o=1.
- dwb_ack_o  out  1  transfer complete, one-cycle pulse.
- dwb_err_o  out  1  transfer error, one-cycle pulse; only used when AEMB_DWB_RAM_ERR_EN is defined.

## Operation
- FSM states: IDLE, WAIT, ACK. The state is held in registers, and all outputs come directly from registers.
- IDLE:
  - If dwb_stb_i=1, capture adr, sel, wre and dat into request registers.
  - Go to ACK if WAIT=0; otherwise load the wait counter with WAIT and go to WAIT.
- WAIT:
  - The counter decrements each cycle, and the FSM moves to ACK when the counter reaches 1.
  - If dwb_stb_i drops while in WAIT, the request is aborted: return to IDLE with no ack, no err and no write.
- ACK:
  - dwb_ack_o=1 for exactly one cycle, and dwb_dat_o holds mem[captured adr].
  - A store commits to memory on the edge that enters ACK. Only lanes with sel bit=1 are written. sel=0 changes nothing and is still acknowledged.
  - Always return to IDLE. A dwb_stb_i that is high in the cycle after ACK is a new request.
- Loads:
  - dwb_dat_o carries the full stored word, independent of sel; the core selects the lanes it needs.
  - The read uses the captured address and is registered into dwb_dat_o on the edge entering ACK.
  - dwb_dat_o returns to 0 when ack deasserts.
- A request arriving while the FSM is not in IDLE is not possible, because the core holds its strobe. Inputs outside IDLE are ignored apart from the abort check.

## Timing
- Reset (grst_n=0, asynchronous): state=IDLE, wait counter=0, dwb_ack_o=0, dwb_err_o=0, dwb_dat_o=32'h0. Memory contents are not cleared.
- Reset deasserted in the middle of a transfer: the FSM restarts in IDLE, any pending store is lost, and no ack is issued.
- dwb_stb_i sampled high in IDLE at edge 0 → dwb_ack_o high during cycle WAIT+1, low again the following cycle.
- Store data is visible to a load issued in the cycle immediately after the ack (read-after-write, no hazard).
- Throughput: one transfer per WAIT+2 cycles with back-to-back strobes, because of the IDLE sampling cycle.

## Configuration
- AEMB_DWB_RAM_ERR_EN defined:
  - Legal sel patterns are 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC and 4'hF.
  - Any other non-zero sel, or sel=0 on a store, causes ACK to pulse dwb_err_o instead of dwb_ack_o.
  - On an error, no memory write occurs and dwb_dat_o stays 0.
- AEMB_DWB_RAM_ERR_EN undefined:
  - dwb_err_o is tied to 0.
  - Every request is acknowledged, with lane-masked writes as described above.

## Test plan
- Reset, then WAIT=0: store adr=5, sel=F, dat=32'hDEADBEEF; then load adr=5 → ack one cycle after each strobe; dwb_dat_o=32'hDEADBEEF on the load ack.
- Byte lanes: store adr=5 with sel=8, dat=32'h11111111 and with sel=3, dat=32'h22222222 over 32'hDEADBEEF; then load adr=5 → dwb_dat_o=32'h11AD2222.
- WAIT=3: load strobe at cycle 0 → dwb_ack_o high exactly in cycle 4 and low in cycle 5; drop stb at cycle 2 → no ack, and memory unchanged after a store attempted this way.
- Assert grst_n=0 during the WAIT state of a store to adr=7 (holding 32'hA5A5A5A5) → outputs go to 0 immediately; a subsequent load of adr=7 returns 32'hA5A5A5A5.
- With AEMB_DWB_RAM_ERR_EN: store sel=4'h6 to adr=1 → dwb_err_o pulses, dwb_ack_o stays 0, and adr=1 is unchanged. Without the macro, the same store → ack, and lanes 2 and 1 are written.

Source files
------------

// File: rtl/aemb_dwb_ram.sv
// Wishbone data-bus RAM responder for the AEMB core with a configurable number of wait states.
// Define AEMB_DWB_RAM_ERR_EN to answer illegal byte-lane patterns with dwb_err_o instead of dwb_ack_o.
module aemb_dwb_ram #(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic          gclk,
    input  logic          grst_n,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          dwb_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam int         DEPTH     = 1 << AW;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

    logic [1:0]    stateReg, stateNext;
    logic [3:0]    cntReg, cntNext;
    logic [AW-1:0] adrReg;
    logic [3:0]    selReg;
    logic          wreReg;
    logic [31:0]   datReg;
    logic          ackReg;

    // With no wait states the request goes straight from IDLE to ACK, so the
    // memory must see the live bus rather than the (not yet loaded) capture registers.
    logic          useLive;
    logic [AW-1:0] reqAdr;
    logic [3:0]    reqSel;
    logic          reqWre;
    logic [31:0]   reqDat;

    logic commit;
    logic errReq;
    logic commitOk;
    logic writeEn;

    assign useLive = (stateReg == S_IDLE);
    assign reqAdr  = useLive ? dwb_adr_i : adrReg;
    assign reqSel  = useLive ? dwb_sel_i : selReg;
    assign reqWre  = useLive ? dwb_wre_i : wreReg;
    assign reqDat  = useLive ? dwb_dat_i : datReg;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        commit    = 1'b0;
        case (stateReg)
            S_IDLE: begin
                if (dwb_stb_i) begin
                    if (WAIT == 0) begin
                        stateNext = S_ACK;
                        commit    = 1'b1;
                    end else begin
                        stateNext = S_WAIT;
                        cntNext   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!dwb_stb_i) begin
                    stateNext = S_IDLE;
                    cntNext   = 4'd0;
                end else if (cntReg == 4'd1) begin
                    stateNext = S_ACK;
                    cntNext   = 4'd0;
                    commit    = 1'b1;
                end else begin
                    cntNext = cntReg - 4'd1;
                end
            end
            S_ACK: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

`ifdef AEMB_DWB_RAM_ERR_EN
    logic selLegal;

    always_comb begin
        case (reqSel)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: selLegal = 1'b1;
            default:                                  selLegal = 1'b0;
        endcase
    end

    // An empty lane mask is harmless on a load but meaningless on a store.
    assign errReq = (reqSel == 4'h0) ? reqWre : !selLegal;

    logic errReg;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            errReg <= 1'b0;
        end else begin
            errReg <= commit && errReq;
        end
    end

    assign dwb_err_o = errReg;
`else
    assign errReq    = 1'b0;
    assign dwb_err_o = 1'b0;
`endif

    assign commitOk = commit && !errReq;
    assign writeEn  = commitOk && reqWre;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            stateReg <= S_IDLE;
            cntReg   <= 4'd0;
            ackReg   <= 1'b0;
            adrReg   <= '0;
            selReg   <= 4'h0;
            wreReg   <= 1'b0;
            datReg   <= 32'h0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            ackReg   <= commitOk;
            if (stateReg == S_IDLE && dwb_stb_i) begin
                adrReg <= dwb_adr_i;
                selReg <= dwb_sel_i;
                wreReg <= dwb_wre_i;
                datReg <= dwb_dat_i;
            end
        end
    end

    assign dwb_ack_o = ackReg;

    // One byte-wide RAM per lane; lane gi carries dat[8*gi+7:8*gi] and sel[gi].
    // The read is read-first, so a store ack shows the word as it was before the write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] laneMem [DEPTH];
            logic [7:0] laneQ;

            always_ff @(posedge gclk) begin
                if (writeEn && reqSel[gi]) begin
                    laneMem[reqAdr] <= reqDat[8*gi +: 8];
                end
            end

            always_ff @(posedge gclk or negedge grst_n) begin
                if (!grst_n) begin
                    laneQ <= 8'h0;
                end else if (commitOk) begin
                    laneQ <= laneMem[reqAdr];
                end else begin
                    laneQ <= 8'h0;
                end
            end

            assign dwb_dat_o[8*gi +: 8] = laneQ;
        end
    endgenerate

endmodule

// File: tb/tb_aemb_dwb_ram.sv
// Self-checking bench for aemb_dwb_ram: two instances (no wait states and three wait states)
// checked against a byte-lane memory model kept in the bench.
module tb_aemb_dwb_ram;

    localparam int AW = 10;

`ifdef AEMB_DWB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic gclk   = 1'b0;
    logic grst_n = 1'b0;

    logic          stb  [2];
    logic          wre  [2];
    logic [AW-1:0] adr  [2];
    logic [3:0]    sel  [2];
    logic [31:0]   din  [2];
    logic [31:0]   dout [2];
    logic          ack  [2];
    logic          err  [2];

    int waitOf [2] = '{0, 3};

    logic [31:0] mdl   [2][1024];
    logic [3:0]  known [2][1024];

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 gclk = ~gclk;

    aemb_dwb_ram #(.AW(AW), .WAIT(0)) dut0 (
        .gclk      (gclk),
        .grst_n    (grst_n),
        .dwb_stb_i (stb[0]),
        .dwb_wre_i (wre[0]),
        .dwb_adr_i (adr[0]),
        .dwb_sel_i (sel[0]),
        .dwb_dat_i (din[0]),
        .dwb_dat_o (dout[0]),
        .dwb_ack_o (ack[0]),
        .dwb_err_o (err[0])
    );

    aemb_dwb_ram #(.AW(AW), .WAIT(3)) dut3 (
        .gclk      (gclk),
        .grst_n    (grst_n),
        .dwb_stb_i (stb[1]),
        .dwb_wre_i (wre[1]),
        .dwb_adr_i (adr[1]),
        .dwb_sel_i (sel[1]),
        .dwb_dat_i (din[1]),
        .dwb_dat_o (dout[1]),
        .dwb_ack_o (ack[1]),
        .dwb_err_o (err[1])
    );

    function automatic bit expErr(input bit w, input logic [3:0] s);
        bit legal;
        bit e;
        legal = (s inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
        e     = (s == 4'h0) ? w : !legal;
        return ERR_EN && e;
    endfunction

    function automatic logic [31:0] laneMask(input logic [3:0] k);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[8*l +: 8] = {8{k[l]}};
        return r;
    endfunction

    task automatic modelStore(input int u, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d);
        for (int l = 0; l < 4; l++) begin
            if (s[l]) mdl[u][a][8*l +: 8] = d[8*l +: 8];
        end
        known[u][a] = known[u][a] | s;
    endtask

    // Drives one request and waits (bounded) for ack or err; lat counts negedges from the first one after the strobe.
    task automatic xfer(input int u, input bit w, input logic [9:0] a, input logic [3:0] s, input logic [31:0] d,
                        input bit keepStb, output bit gotAck, output bit gotErr, output logic [31:0] gotDat, output int lat);
        @(posedge gclk);
        #1;
        stb[u] = 1'b1;
        wre[u] = w;
        adr[u] = a;
        sel[u] = s;
        din[u] = d;
        lat    = -1;
        gotAck = 1'b0;
        gotErr = 1'b0;
        gotDat = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge gclk);
            if (ack[u] === 1'b1 || err[u] === 1'b1) begin
                lat    = k;
                gotAck = ack[u];
                gotErr = err[u];
                gotDat = dout[u];
                break;
            end
        end
        if (!keepStb) stb[u] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge gclk);
        for (int u = 0; u < 2; u++) begin
            totalCnt++;
            if (ack[u] !== 1'b0) $display("FAIL reset_ack u%0d: got %b, expected 0", u, ack[u]);
            else passCnt++;
            totalCnt++;
            if (err[u] !== 1'b0) $display("FAIL reset_err u%0d: got %b, expected 0", u, err[u]);
            else passCnt++;
            totalCnt++;
            if (dout[u] !== 32'h0) $display("FAIL reset_dat u%0d: got %h, expected 00000000", u, dout[u]);
            else passCnt++;
        end
        grst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_basic;
        bit gA, gE;
        logic [31:0] gD;
        int lat;
        xfer(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, gA, gE, gD, lat);
        modelStore(0, 10'd5, 4'hF, 32'hDEADBEEF);
        $display("store u0 adr=5 sel=F dat=DEADBEEF ack=%0b lat=%0d", gA, lat);
        totalCnt++;
        if (gA !== 1'b1 || gE !== 1'b0 || lat != 1) $display("FAIL basic_store: ack=%0b err=%0b lat=%0d, expected ack=1 err=0 lat=1", gA, gE, lat);
        else passCnt++;
        @(negedge gclk);
        totalCnt++;
        if (ack[0] !== 1'b0 || dout[0] !== 32'h0) $display("FAIL ack_pulse: ack=%b dat=%h after ack cycle, expected 0/00000000", ack[0], dout[0]);
        else passCnt++;
        xfer(0, 1'b0, 10'd5, 4'hF, 32'h0, 1'b0, gA, gE, gD, lat);
        $display("load  u0 adr=5 ack=%0b lat=%0d dat=%h", gA, lat, gD);
        totalCnt++;
        if (gA !== 1'b1 || lat != 1 || gD !== 32'hDEADBEEF) $display("FAIL basic_load: ack=%0b lat=%0d dat=%h, expected ack=1 lat=1 dat=deadbeef", gA, lat, gD);
        else passCnt++;
        @(negedge gclk);
        totalCnt++;
        if (dout[0] !== 32'h0) $display("FAIL dat_clear: got %h, expected 00000000", dout[0]);
        else passCnt++;
    endtask

    task automatic test_byte_lanes;
        bit gA, gE;
        logic [31:0] gD;
        int lat;
        xfer(0, 1'b1, 10'd5, 4'h8, 32'h11111111, 1'b0, gA, gE, gD, lat);
        modelStore(0, 10'd5, 4'h8, 32'h11111111);
        $display("store u0 adr=5 sel=8 dat=11111111 ack=%0b", gA);
        xfer(0, 1'b1, 10'd5, 4'h3, 32'h22222222, 1'b0, gA, gE, gD, lat);
        modelStore(0, 10'd5, 4'h3, 32'h22222222);
        $display("store u0 adr=5 sel=3 dat=22222222 ack=%0b", gA);
        xfer(0, 1'b0, 10'd5, 4'h1, 32'h0, 1'b0, gA, gE, gD, lat);
        $display("load  u0 adr=5 sel=1 ack=%0b dat=%h", gA, gD);
        totalCnt++;
        if (gA !== 1'b1 || gD !== 32'h11AD2222) $display("FAIL byte_lanes: ack=%0b dat=%h, expected ack=1 dat=11ad2222", gA, gD);
        else passCnt++;
    endtask

    task automatic test_wait_states;
        bit gA, gE;
        logic [31:0] gD, d;
        int lat;
        d = $urandom;
        xfer(1, 1'b1, 10'd9, 4'hF, d, 1'b0, gA, gE, gD, lat);
        modelStore(1, 10'd9, 4'hF, d);
        $display("store u1 adr=9 dat=%h ack=%0b lat=%0d", d, gA, lat);
        xfer(1, 1'b0, 10'd9, 4'hF, 32'h0, 1'b0, gA, gE, gD, lat);
        $display("load  u1 adr=9 ack=%0b lat=%0d dat=%h", gA, lat, gD);
        totalCnt++;
        if (gA !== 1'b1 || lat != 4 || gD !== d) $display("FAIL wait3_load: ack=%0b lat=%0d dat=%h, expected ack=1 lat=4 dat=%h", gA, lat, gD, d);
        else passCnt++;
        @(negedge gclk);
        totalCnt++;
        if (ack[1] !== 1'b0) $display("FAIL wait3_ack_low: got %b in cycle 5, expected 0", ack[1]);
        else passCnt++;
    endtask

    task automatic test_abort;
        bit gA, gE, seen;
        logic [31:0] gD;
        int lat;
        @(posedge gclk);
        #1;
        stb[1] = 1'b1;
        wre[1] = 1'b1;
        adr[1] = 10'd9;
        sel[1] = 4'hF;
        din[1] = ~mdl[1][9];
        seen   = 1'b0;
        repeat (3) begin
            @(negedge gclk);
            if (ack[1] === 1'b1 || err[1] === 1'b1) seen = 1'b1;
        end
        stb[1] = 1'b0;
        repeat (8) begin
            @(negedge gclk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen = 1'b1;
        end
        $display("abort u1 store adr=9 response_seen=%0b", seen);
        totalCnt++;
        if (seen) $display("FAIL abort_no_ack: response seen=1, expected 0");
        else passCnt++;
        xfer(1, 1'b0, 10'd9, 4'hF, 32'h0, 1'b0, gA, gE, gD, lat);
        $display("load  u1 adr=9 after abort dat=%h", gD);
        totalCnt++;
        if (gA !== 1'b1 || gD !== mdl[1][9]) $display("FAIL abort_mem: ack=%0b dat=%h, expected ack=1 dat=%h", gA, gD, mdl[1][9]);
        else passCnt++;
    endtask

    task automatic test_reset_mid;
        bit gA, gE, seen;
        logic [31:0] gD;
        int lat;
        xfer(1, 1'b1, 10'd7, 4'hF, 32'hA5A5A5A5, 1'b0, gA, gE, gD, lat);
        modelStore(1, 10'd7, 4'hF, 32'hA5A5A5A5);
        $display("store u1 adr=7 dat=a5a5a5a5 ack=%0b", gA);
        totalCnt++;
        if (gA !== 1'b1 || lat != 4) $display("FAIL mid_prep: ack=%0b lat=%0d, expected ack=1 lat=4", gA, lat);
        else passCnt++;
        @(posedge gclk);
        #1;
        stb[1] = 1'b1;
        wre[1] = 1'b1;
        adr[1] = 10'd7;
        sel[1] = 4'hF;
        din[1] = 32'h12345678;
        @(negedge gclk);
        @(negedge gclk);
        grst_n = 1'b0;
        #1;
        totalCnt++;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0 || dout[1] !== 32'h0)
            $display("FAIL mid_reset_out: ack=%b err=%b dat=%h, expected 0/0/00000000", ack[1], err[1], dout[1]);
        else passCnt++;
        stb[1] = 1'b0;
        seen   = 1'b0;
        repeat (2) @(negedge gclk);
        grst_n = 1'b1;
        repeat (6) begin
            @(negedge gclk);
            if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen = 1'b1;
        end
        totalCnt++;
        if (seen) $display("FAIL mid_reset_noack: response seen=1, expected 0");
        else passCnt++;
        xfer(1, 1'b0, 10'd7, 4'hF, 32'h0, 1'b0, gA, gE, gD, lat);
        $display("load  u1 adr=7 after reset dat=%h", gD);
        totalCnt++;
        if (gA !== 1'b1 || gD !== 32'hA5A5A5A5) $display("FAIL mid_reset_mem: ack=%0b dat=%h, expected ack=1 dat=a5a5a5a5", gA, gD);
        else passCnt++;
    endtask

    task automatic test_sel6;
        bit gA, gE, e;
        logic [31:0] gD, base, d;
        int lat;
        for (int u = 0; u < 2; u++) begin
            base = $urandom;
            d    = $urandom;
            xfer(u, 1'b1, 10'd1, 4'hF, base, 1'b0, gA, gE, gD, lat);
            modelStore(u, 10'd1, 4'hF, base);
            e = expErr(1'b1, 4'h6);
            xfer(u, 1'b1, 10'd1, 4'h6, d, 1'b0, gA, gE, gD, lat);
            $display("store u%0d adr=1 sel=6 dat=%h ack=%0b err=%0b", u, d, gA, gE);
            totalCnt++;
            if (gA !== !e || gE !== e || lat != waitOf[u] + 1)
                $display("FAIL sel6_resp u%0d: ack=%0b err=%0b lat=%0d, expected ack=%0b err=%0b lat=%0d", u, gA, gE, lat, !e, e, waitOf[u] + 1);
            else passCnt++;
            if (e) begin
                totalCnt++;
                if (gD !== 32'h0) $display("FAIL sel6_errdat u%0d: got %h, expected 00000000", u, gD);
                else passCnt++;
            end else begin
                modelStore(u, 10'd1, 4'h6, d);
            end
            xfer(u, 1'b0, 10'd1, 4'hF, 32'h0, 1'b0, gA, gE, gD, lat);
            totalCnt++;
            if (gA !== 1'b1 || gD !== mdl[u][1]) $display("FAIL sel6_mem u%0d: ack=%0b dat=%h, expected ack=1 dat=%h", u, gA, gD, mdl[u][1]);
            else passCnt++;
        end
    endtask

    // Random transfers; with chained=1 the strobe stays high from one request into the next.
    task automatic test_stream(input int u, input bit chained, input int n);
        bit w, gA, gE, e;
        logic [9:0]  a;
        logic [3:0]  s;
        logic [31:0] d, gD, m, expD;
        int lat;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 10'($urandom_range(0, 15));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            e = expErr(w, s);
            xfer(u, w, a, s, d, chained && (i != n - 1), gA, gE, gD, lat);
            $display("xfer u%0d %s adr=%0d sel=%h dat=%h ack=%0b err=%0b lat=%0d rdat=%h",
                     u, w ? "st" : "ld", a, s, d, gA, gE, lat, gD);
            totalCnt++;
            if (gA !== !e || gE !== e || lat != waitOf[u] + 1)
                $display("FAIL stream_resp u%0d #%0d: ack=%0b err=%0b lat=%0d, expected ack=%0b err=%0b lat=%0d",
                         u, i, gA, gE, lat, !e, e, waitOf[u] + 1);
            else passCnt++;
            if (e || !w) begin
                m    = e ? 32'hFFFFFFFF : laneMask(known[u][a]);
                expD = e ? 32'h0 : mdl[u][a];
                totalCnt++;
                if ((gD & m) !== (expD & m))
                    $display("FAIL stream_dat u%0d #%0d adr=%0d: got %h, expected %h (lane mask %h)", u, i, a, gD, expD, m);
                else passCnt++;
            end
            if (w && !e) modelStore(u, a, s, d);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            stb[u] = 1'b0;
            wre[u] = 1'b0;
            adr[u] = '0;
            sel[u] = 4'h0;
            din[u] = 32'h0;
            for (int a = 0; a < 1024; a++) begin
                mdl[u][a]   = 32'h0;
                known[u][a] = 4'h0;
            end
        end
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wait_states();
        test_abort();
        test_reset_mid();
        test_sel6();
        test_stream(0, 1'b1, 20);
        test_stream(1, 1'b1, 12);
        test_stream(0, 1'b0, 30);
        test_stream(1, 1'b0, 20);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
